// File: rtl/rsa_modexp.sv
// Sequential modular exponentiation, result = base^exponent mod modulus, using right-to-left
// square-and-multiply over bit-serial interleaved modmul. Optional macro: RSA_CONST_TIME_EN.
module rsa_modexp #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned EXP_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     base_i,
    input  logic [EXP_WIDTH-1:0] exponent_i,
    input  logic [WIDTH-1:0]     modulus_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [WIDTH-1:0]     result_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned KW   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [KW-1:0]   KLast   = KW'(EXP_WIDTH - 1);

`ifdef RSA_CONST_TIME_EN
    localparam bit ConstTime = 1'b1;
`else
    localparam bit ConstTime = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StReduce, StMult, StSquare, StFinish} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [KW-1:0]        k_q, k_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [WIDTH-1:0]     mul_b;
    logic [WIDTH:0]       nn, dbl, red1, sum, red2;
    logic [WIDTH-1:0]     prod;
    logic [EXP_WIDTH-1:0] exp_shr;

    // One interleaved-modmul iteration; acc stays < n, so WIDTH+1 bits never overflow.
    always_comb begin
        mul_b = (state_q == StReduce) ? WIDTH'(1) : b_q;
        nn    = {1'b0, mod_q};
        dbl   = {acc_q, 1'b0};
        red1  = (dbl >= nn) ? dbl - nn : dbl;
        sum   = red1 + (a_q[WIDTH-1] ? {1'b0, mul_b} : '0);
        red2  = (sum >= nn) ? sum - nn : sum;
        prod  = WIDTH'(red2);
    end

    assign exp_shr = exp_q >> 1;

    always_comb begin
        state_d  = state_q;
        mod_d    = mod_q;
        exp_d    = exp_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !done_q) begin
                    mod_d   = modulus_i;
                    exp_d   = exponent_i;
                    a_d     = base_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    k_d     = '0;
                    err_d   = 1'b0;
                    // 1 mod n; also yields result 0 on the modulus==0 error path
                    r_d     = (modulus_i <= WIDTH'(1)) ? '0 : WIDTH'(1);
                    state_d = (modulus_i == '0) ? StFinish : StReduce;
                end
            end
            StReduce, StMult, StSquare: begin
                acc_d = prod;
                a_d   = a_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (state_q == StReduce) begin
                        b_d = prod;
                        if (ConstTime || exp_q[0]) begin
                            state_d = StMult;
                            a_d     = r_q;
                        end else begin
                            state_d = StSquare;
                            a_d     = prod;
                        end
                    end else if (state_q == StMult) begin
                        if (exp_q[0]) r_d = prod;
                        state_d = StSquare;
                        a_d     = b_q;
                    end else begin
                        b_d   = prod;
                        exp_d = exp_shr;
                        k_d   = k_q + 1'b1;
                        if (k_q == KLast) begin
                            state_d = StFinish;
                        end else if (ConstTime || exp_shr[0]) begin
                            state_d = StMult;
                            a_d     = r_q;
                        end else begin
                            state_d = StSquare;
                            a_d     = prod;
                        end
                    end
                end
            end
            StFinish: begin
                result_d = r_q;
                done_d   = 1'b1;
                err_d    = (mod_q == '0);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            mod_q    <= '0;
            exp_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mod_q    <= mod_d;
            exp_q    <= exp_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // done is registered out of FINISH, so busy covers the done cycle as well
    assign busy_o   = (state_q != StIdle) || done_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign result_o = result_q;

endmodule

// File: doc/rsa_modexp.md
Name: rsa_modexp

Overview:
Sequential modular exponentiation engine: computes result = base^exponent mod modulus. Consumes the private exponent d produced by d_calc (decrypt: m = c^d mod n) and the public exponent e (encrypt: c = m^e mod n). Uses right-to-left square-and-multiply over bit-serial interleaved modular multiplication, so there is no wide multiplier and no divider. One request in flight at a time.

Parameters:
WIDTH, 128, bit width of base, modulus, result
EXP_WIDTH, 128, bit width of exponent; all EXP_WIDTH bits are scanned

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request strobe; accepted only when busy=0
base  input  WIDTH  message/ciphertext; may be >= modulus
exponent  input  EXP_WIDTH  e or d
modulus  input  WIDTH  n
busy  output  1  high from the cycle after accept until the done cycle, inclusive
done  output  1  one-cycle pulse; result valid
err  output  1  high with done when modulus==0; held until next accept
result  output  WIDTH  base^exponent mod modulus; held until next accept

Behaviour:
- Reset (asynchronous, any time including mid-operation): state IDLE; busy=0, done=0, err=0, result=0; internal registers cleared. Any in-flight operation is discarded.
- Accept: start=1 and busy=0 at a rising edge. Latch base, exponent and modulus. Clear err. Input changes after accept have no effect. start while busy=1 is ignored and is not queued.
- States: IDLE -> REDUCE -> (MULT) -> SQUARE -> ... -> FINISH -> IDLE.
- modulus==0 at accept: go to FINISH directly. done=1 and err=1 one cycle after accept; result=0.
- modmul(a,b) is the core primitive. Precondition: b < n. acc starts at 0. For i = WIDTH-1 down to 0, one iteration per cycle:
  - acc = 2*acc; if acc >= n then acc -= n
  - if a[i]: acc += b; if acc >= n then acc -= n
  - acc needs WIDTH+1 bits internally.
  - Exactly WIDTH cycles per modmul.
- REDUCE (WIDTH cycles): B = modmul(base, 1), i.e. base mod n. R initialised to 1 mod n: 0 if n==1, else 1.
- Exponent bits are processed k = 0..EXP_WIDTH-1, LSB first. For each bit:
  - if exponent[k]==1: MULT (WIDTH cycles), R = modmul(R, B)
  - then SQUARE (WIDTH cycles), B = modmul(B, B); the square is performed for every bit, including the last.
- FINISH (1 cycle): result=R, done=1, busy=0 next cycle, return to IDLE. A new start is accepted in the cycle after done.
- Latency, accept edge to done cycle: WIDTH*(1 + EXP_WIDTH + popcount(exponent)) + 1 cycles.
- Boundaries:
  - exponent==0 gives result = 1 mod n.
  - modulus==1 gives result 0.
  - base==0 with nonzero exponent gives result 0.
  - 0^0 gives 1 mod n.
  - Full-scale values (all ones) must not overflow the WIDTH+1-bit accumulator.

Optional Feature:
RSA_CONST_TIME_EN
- Defined: MULT runs for every exponent bit, and its result is written to R only when the bit is 1. Latency is fixed at WIDTH*(1 + 2*EXP_WIDTH) + 1 cycles, independent of the exponent value (timing side-channel hardening).
- Undefined: MULT is skipped for zero bits; latency is as given in Behaviour.
- Results are identical in both builds.

Test Plan:
1. WIDTH=16, EXP_WIDTH=16: base=4, exponent=13, modulus=497 -> result=445, err=0. Without RSA_CONST_TIME_EN, done arrives 16*(1+16+3)+1=321 cycles after accept.
2. WIDTH=16, EXP_WIDTH=16, RSA round trip. base=65, exponent=17, modulus=3233 -> result=2790. Then base=2790, exponent=2753, modulus=3233 -> result=65; start is asserted in the cycle after the first done.
3. Boundaries:
   - base=1000, exponent=1, modulus=7 -> 6
   - base=5, exponent=0, modulus=7 -> 1
   - base=9, exponent=5, modulus=1 -> 0
   - base=0, exponent=3, modulus=11 -> 0
4. modulus=0, any base/exponent -> done and err asserted 1 cycle after accept, result=0. A following valid request clears err.
5. Assert start again mid-operation with different inputs -> ignored; first result unchanged. Assert rst mid-operation -> busy/done/result go to 0 immediately (async); a fresh request afterwards completes correctly.
6. WIDTH=128, EXP_WIDTH=128: modulus=2^127-1, base=3, exponent=modulus-1 -> result=1 (Fermat, prime modulus). With RSA_CONST_TIME_EN, latency = 128*257+1 = 32897 cycles for both exponent=1 and exponent=2^128-1.
